// File: rtl/axi_sram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_if
//   AXI4 channel bundle for the axi_sram_slave SRAM target.
//   The 64-bit data path is fixed. Only the ID width is configurable.
//
//   Channels:
//     AW : awvalid/awready, awid, awaddr, awlen, awsize, awburst
//     W  : wvalid/wready, wdata, wstrb, wlast
//     B  : bvalid/bready, bid, bresp
//     AR : arvalid/arready, arid, araddr, arlen, arsize, arburst
//     R  : rvalid/rready, rid, rdata, rresp, rlast
//
//   Modports:
//     master : the initiator side, which drives the requests.
//     slave  : the SRAM side, which drives the ready, response and read data.
// ---------------------------------------------------------------------------
interface axi_sram_slave_if #(
    parameter int ID_W = 4
);
    logic            awvalid;
    logic            awready;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;

    logic            wvalid;
    logic            wready;
    logic [63:0]     wdata;
    logic [7:0]      wstrb;
    logic            wlast;

    logic            bvalid;
    logic            bready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;

    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;

    logic            rvalid;
    logic            rready;
    logic [ID_W-1:0] rid;
    logic [63:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//   AXI4 slave in front of a DEPTH x 64-bit SRAM that serves byte addresses
//   [BASE, BASE + DEPTH*8). The read channel and the write channel each have
//   their own FSM, and the two FSMs run independently of each other.
//   Every access is word-aligned and 64 bits wide. Address bits [2:0] and
//   the awsize/arsize fields are ignored.
//
//   Ports:
//     clock : the only clock. It is active on the rising edge.
//     reset : synchronous, active-high. A reset abandons any burst that is
//             in progress. It does not clear the SRAM contents.
//     bus   : the axi_sram_slave_if.slave bundle (AW/W/B/AR/R channels).
//
//   Build option:
//     AXI_SRAM_SLAVE_BURST_EN
//       Defined     : awlen and arlen are honoured (1-256 beats). FIXED
//                     bursts stay on one word. INCR and WRAP bursts both
//                     step the address by 8 on each beat.
//       Not defined : every transaction is a single beat, and
//                     len/burst are ignored.
//
//   Responses: DECERR (2'b11) for beats outside the window. Such write beats
//   are dropped, and such read beats return zero data. SLVERR (2'b10) when
//   wlast does not match the final counted beat.
// ---------------------------------------------------------------------------
module axi_sram_slave #(
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int          DEPTH = 1024,
    parameter int          ID_W  = 4
) (
    input  logic            clock,
    input  logic            reset,
    axi_sram_slave_if.slave bus
);
    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 8);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [63:0] mem [DEPTH];

    // -----------------------------------------------------------------------
    // Burst configuration
    // -----------------------------------------------------------------------
    logic [7:0] aw_len, ar_len;
    logic       aw_fixed, ar_fixed;
    logic       unused_inputs;

`ifdef AXI_SRAM_SLAVE_BURST_EN
    // WRAP is not a FIXED burst, so it steps the address exactly like INCR.
    assign aw_len        = bus.awlen;
    assign ar_len        = bus.arlen;
    assign aw_fixed      = (bus.awburst == 2'b00);
    assign ar_fixed      = (bus.arburst == 2'b00);
    assign unused_inputs = ^{bus.awsize, bus.arsize, bus.awaddr[2:0], bus.araddr[2:0]};
`else
    assign aw_len        = 8'd0;
    assign ar_len        = 8'd0;
    assign aw_fixed      = 1'b1;
    assign ar_fixed      = 1'b1;
    assign unused_inputs = ^{bus.awsize, bus.arsize, bus.awaddr[2:0], bus.araddr[2:0],
                             bus.awlen, bus.arlen, bus.awburst, bus.arburst};
`endif

    // -----------------------------------------------------------------------
    // Write channel
    // -----------------------------------------------------------------------
    w_state_t        w_state, w_next;
    logic [31:0]     w_addr;
    logic [ID_W-1:0] w_id;
    logic [7:0]      w_len, w_cnt;
    logic            w_fixed, w_decerr, w_slverr;
    logic            aw_hs, w_hs, w_last_beat, w_in_range;
    logic [31:0]     w_off;
    logic [IDX_W-1:0] w_idx;

    assign aw_hs       = bus.awvalid && (w_state == W_IDLE);
    assign w_hs        = bus.wvalid && (w_state == W_DATA);
    assign w_last_beat = (w_cnt == w_len);
    // A single unsigned compare on the offset rejects addresses on both
    // sides of the window: below BASE, the subtraction wraps to a large value.
    assign w_off       = w_addr - BASE;
    assign w_in_range  = (w_off < SPAN);
    assign w_idx       = w_off[IDX_W+2:3];

    // NOTE: synchronous state uses non-blocking assignments, so every
    // always_ff samples the values from before the edge, whatever order
    // the blocks are written in.
    always_ff @(posedge clock) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // NOTE: the default assignment at the top gives every path a value,
    // so this combinational block cannot infer a latch.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (bus.awvalid)                w_next = W_DATA;
            W_DATA:  if (bus.wvalid && w_last_beat)  w_next = W_RESP;
            W_RESP:  if (bus.bready)                 w_next = W_IDLE;
            default:                                 w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_addr   <= '0;
            w_id     <= '0;
            w_len    <= '0;
            w_cnt    <= '0;
            w_fixed  <= 1'b0;
            w_decerr <= 1'b0;
            w_slverr <= 1'b0;
        end else if (aw_hs) begin
            w_addr   <= {bus.awaddr[31:3], 3'b000};
            w_id     <= bus.awid;
            w_len    <= aw_len;
            w_cnt    <= '0;
            w_fixed  <= aw_fixed;
            w_decerr <= 1'b0;
            w_slverr <= 1'b0;
        end else if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (!w_fixed)                    w_addr   <= w_addr + 32'd8;
            if (!w_in_range)                 w_decerr <= 1'b1;
            if (bus.wlast != w_last_beat)    w_slverr <= 1'b1;
        end
    end

    // NOTE: the SRAM array has no reset. The array is storage, not control
    // state, and its contents must survive a reset that abandons a burst.
    always_ff @(posedge clock) begin
        if (w_hs && w_in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.wstrb[b]) mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read channel
    // -----------------------------------------------------------------------
    r_state_t        r_state, r_next;
    logic [31:0]     r_addr;
    logic [ID_W-1:0] rid_q;
    logic [7:0]      r_len, r_cnt;
    logic            r_fixed, rlast_q;
    logic [63:0]     rdata_q;
    logic [1:0]      rresp_q;
    logic            ar_hs, r_hs, r_load, r_in_range;
    logic [31:0]     r_fetch_addr, ar_addr_al, r_off;
    logic [IDX_W-1:0] r_idx;

    assign ar_hs        = bus.arvalid && (r_state == R_IDLE);
    assign r_hs         = bus.rready && (r_state == R_DATA);
    // The output register is reloaded on AR acceptance and on every R
    // handshake except the last, so rvalid stays high with no bubble.
    assign r_load       = ar_hs || (r_hs && !rlast_q);
    assign ar_addr_al   = {bus.araddr[31:3], 3'b000};
    assign r_fetch_addr = (r_state == R_IDLE) ? ar_addr_al : r_addr;
    assign r_off        = r_fetch_addr - BASE;
    assign r_in_range   = (r_off < SPAN);
    assign r_idx        = r_off[IDX_W+2:3];

    always_ff @(posedge clock) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (bus.arvalid)             r_next = R_DATA;
            R_DATA:  if (bus.rready && rlast_q)   r_next = R_IDLE;
            default:                              r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr  <= '0;
            rid_q   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            rlast_q <= 1'b0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else begin
            // The SRAM write in the same cycle has not landed yet, so a
            // read of the same word returns the old data.
            if (r_load) begin
                rdata_q <= r_in_range ? mem[r_idx] : 64'd0;
                rresp_q <= r_in_range ? 2'b00 : 2'b11;
            end
            if (ar_hs) begin
                rid_q   <= bus.arid;
                r_len   <= ar_len;
                r_cnt   <= '0;
                r_fixed <= ar_fixed;
                rlast_q <= (ar_len == 8'd0);
                r_addr  <= ar_fixed ? ar_addr_al : ar_addr_al + 32'd8;
            end else if (r_hs) begin
                if (rlast_q) begin
                    rlast_q <= 1'b0;
                end else begin
                    r_cnt   <= r_cnt + 8'd1;
                    rlast_q <= ((r_cnt + 8'd1) == r_len);
                    if (!r_fixed) r_addr <= r_addr + 32'd8;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        bus.awready = (w_state == W_IDLE);
        bus.wready  = (w_state == W_DATA);
        bus.bvalid  = (w_state == W_RESP);
        bus.bid     = w_id;
        bus.bresp   = w_decerr ? 2'b11 : (w_slverr ? 2'b10 : 2'b00);
        bus.arready = (r_state == R_IDLE);
        bus.rvalid  = (r_state == R_DATA);
        bus.rid     = rid_q;
        bus.rdata   = rdata_q;
        bus.rresp   = rresp_q;
        bus.rlast   = rlast_q;
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
//   Self-checking bench for axi_sram_slave. It contains:
//     - a table of write-then-read vectors
//     - hand-written sequences for the multi-cycle corners: same-cycle
//       read/write, stalls, reset in the middle of a transaction, and bursts
//     - a randomized single-beat phase checked against a word-array model
//   Inputs are driven, and outputs sampled, on the falling edge of clock.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 8);
    localparam int          TO    = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [63:0] model [int];

    axi_sram_slave_if #(.ID_W(4)) bus ();

    axi_sram_slave #(.BASE(BASE), .DEPTH(DEPTH), .ID_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        total++;
        bad++;
        $display("FAIL %s: no handshake within %0d cycles", nm, TO);
    endtask

    // ---------------- channel tasks (enter and leave at a negedge) -------
    task automatic do_aw(input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        bus.awvalid = 1'b1; bus.awaddr = addr; bus.awid = id;
        bus.awlen = len; bus.awburst = burst; bus.awsize = 3'($urandom);
        while (!bus.awready && n < TO) begin @(negedge clock); n++; end
        if (!bus.awready) expire("aw_handshake");
        @(negedge clock);
        bus.awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
        while (!bus.wready && n < TO) begin @(negedge clock); n++; end
        if (!bus.wready) expire("w_handshake");
        @(negedge clock);
        bus.wvalid = 1'b0;
    endtask

    task automatic do_b(input logic [3:0] id, input logic [1:0] resp, input string nm);
        int n = 0;
        bus.bready = 1'b1;
        while (!bus.bvalid && n < TO) begin @(negedge clock); n++; end
        if (!bus.bvalid) expire({nm, "_bvalid"});
        else begin
            check({nm, "_bid"}, bus.bid, id);
            check({nm, "_bresp"}, bus.bresp, resp);
        end
        @(negedge clock);
        bus.bready = 1'b0;
        check({nm, "_bvalid_drop"}, bus.bvalid, 1'b0);
        check({nm, "_awready_back"}, bus.awready, 1'b1);
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arid = id;
        bus.arlen = len; bus.arburst = burst; bus.arsize = 3'($urandom);
        while (!bus.arready && n < TO) begin @(negedge clock); n++; end
        if (!bus.arready) expire("ar_handshake");
        @(negedge clock);
        bus.arvalid = 1'b0;
        check("ar_rvalid_next_cycle", bus.rvalid, 1'b1);
        check("ar_arready_low", bus.arready, 1'b0);
    endtask

    task automatic do_r(input logic [3:0] id, input logic [63:0] data, input logic [1:0] resp,
                        input logic last, input string nm);
        int n = 0;
        bus.rready = 1'b1;
        while (!bus.rvalid && n < TO) begin @(negedge clock); n++; end
        if (!bus.rvalid) expire({nm, "_rvalid"});
        else begin
            check({nm, "_rid"}, bus.rid, id);
            check({nm, "_rdata"}, bus.rdata, data);
            check({nm, "_rresp"}, bus.rresp, resp);
            check({nm, "_rlast"}, bus.rlast, last);
        end
        @(negedge clock);
        bus.rready = 1'b0;
        if (last) begin
            check({nm, "_arready_after"}, bus.arready, 1'b1);
            check({nm, "_rvalid_after"}, bus.rvalid, 1'b0);
        end
    endtask

    // Single-beat helpers. In the non-burst build, junk len/burst values
    // are sent to show that they are ignored.
    task automatic write1(input logic [31:0] addr, input logic [3:0] id, input logic [63:0] data,
                          input logic [7:0] strb, input logic last, input logic [1:0] resp,
                          input string nm);
`ifdef AXI_SRAM_SLAVE_BURST_EN
        do_aw(addr, id, 8'd0, 2'b01);
`else
        do_aw(addr, id, 8'($urandom), 2'($urandom));
`endif
        do_w(data, strb, last);
        do_b(id, resp, nm);
    endtask

    task automatic read1(input logic [31:0] addr, input logic [3:0] id, input logic [63:0] data,
                         input logic [1:0] resp, input string nm);
`ifdef AXI_SRAM_SLAVE_BURST_EN
        do_ar(addr, id, 8'd0, 2'b01);
`else
        do_ar(addr, id, 8'($urandom), 2'($urandom));
`endif
        do_r(id, data, resp, 1'b1, nm);
    endtask

    // ---------------- reference model helpers -----------------------------
    function automatic logic in_win(input logic [31:0] a);
        longint unsigned x = longint'(a);
        return (x >= longint'(BASE)) && (x < longint'(BASE) + longint'(SPAN));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        int w;
        logic [63:0] v;
        if (in_win(a)) begin
            w = word_of(a);
            v = model.exists(w) ? model[w] : 64'd0;
            for (int b = 0; b < 8; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
            model[w] = v;
        end
    endtask

    task automatic run_random();
        logic [31:0] rbase = BASE + 32'h400;
        logic [31:0] a;
        logic [63:0] d;
        logic [7:0]  s;
        for (int k = 0; k < 8; k++) begin
            d = {$urandom, $urandom};
            write1(rbase + 32'(8 * k), 4'(k), d, 8'hFF, 1'b1, 2'b00, "rnd_init");
            model_write(rbase + 32'(8 * k), d, 8'hFF);
        end
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(0, 1) == 0) ? BASE - 32'(8 * $urandom_range(1, 4))
                                                : BASE + SPAN + 32'(8 * $urandom_range(0, 3));
            else
                a = rbase + 32'(8 * $urandom_range(0, 7)) + 32'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                d = {$urandom, $urandom};
                s = 8'($urandom);
                write1(a, 4'(i), d, s, 1'b1, in_win(a) ? 2'b00 : 2'b11, "rnd_wr");
                model_write(a, d, s);
            end else begin
                read1(a, 4'(i), in_win(a) ? model[word_of(a)] : 64'd0,
                      in_win(a) ? 2'b00 : 2'b11, "rnd_rd");
            end
        end
    endtask

`ifdef AXI_SRAM_SLAVE_BURST_EN
    // Reads a burst with rready toggling every cycle. It checks that there
    // is no bubble, that the outputs hold during stalls, and that the data
    // arrives in order.
    task automatic read_toggle(input logic [31:0] addr, input logic [7:0] len,
                               input logic [63:0] exp_q[$], input string nm);
        int got = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [63:0] prev_data = '0;
        logic prev_last = 1'b0;
        do_ar(addr, 4'd9, len, 2'b01);
        while (got <= int'(len) && cyc < 4 * TO) begin
            bus.rready = (cyc % 2 == 1);
            check({nm, "_no_bubble"}, bus.rvalid, 1'b1);
            if (prev_stall) begin
                check({nm, "_hold_data"}, bus.rdata, prev_data);
                check({nm, "_hold_last"}, bus.rlast, prev_last);
            end
            if (bus.rvalid && bus.rready) begin
                check($sformatf("%s_beat%0d_data", nm, got), bus.rdata, exp_q[got]);
                check($sformatf("%s_beat%0d_last", nm, got), bus.rlast, got == int'(len));
                got++;
            end
            prev_stall = bus.rvalid && !bus.rready;
            prev_data  = bus.rdata;
            prev_last  = bus.rlast;
            @(negedge clock);
            cyc++;
        end
        bus.rready = 1'b0;
        if (got <= int'(len)) expire({nm, "_beats"});
        check({nm, "_arready_after"}, bus.arready, 1'b1);
    endtask
`endif

    typedef struct {
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        wlast;
        logic [1:0]  exp_bresp;
        logic [63:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{BASE + 32'h000, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b1, 2'b00, 64'hDEAD_BEEF_0BAD_F00D, 2'b00});
        vecs.push_back('{BASE + 32'h010, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, 2'b00, 64'h1122_3344_5566_7788, 2'b00});
        vecs.push_back('{BASE + 32'h020, 64'h0,                   8'hFF, 1'b1, 2'b00, 64'h0,                   2'b00});
        vecs.push_back('{BASE + 32'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1, 2'b00, 64'h0000_0000_FFFF_FFFF, 2'b00});
        vecs.push_back('{BASE + 32'h025, 64'hA5A5_A5A5_A5A5_A5A5, 8'hF0, 1'b1, 2'b00, 64'hA5A5_A5A5_FFFF_FFFF, 2'b00});
        vecs.push_back('{BASE + 32'h030, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 2'b10, 64'h0123_4567_89AB_CDEF, 2'b00});
        vecs.push_back('{BASE + SPAN,    64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 1'b1, 2'b11, 64'h0,                   2'b11});
        vecs.push_back('{32'h7FFF_FFF8,  64'hBEEF_BEEF_BEEF_BEEF, 8'hFF, 1'b1, 2'b11, 64'h0,                   2'b11});
        vecs.push_back('{BASE + SPAN - 8, 64'h5555_6666_7777_8888, 8'hFF, 1'b1, 2'b00, 64'h5555_6666_7777_8888, 2'b00});
        vecs.push_back('{BASE + 32'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, 2'b00, 64'h1122_3344_5566_7788, 2'b00});
        vecs.push_back('{BASE + 32'h010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h81, 1'b1, 2'b00, 64'hAA22_3344_5566_77AA, 2'b00});
        vecs.push_back('{BASE + 32'h040, 64'h1111_1111_1111_1111, 8'hFF, 1'b1, 2'b00, 64'h1111_1111_1111_1111, 2'b00});
        vecs.push_back('{BASE + 32'h050, 64'h5050_5050_5050_5050, 8'hFF, 1'b1, 2'b00, 64'h5050_5050_5050_5050, 2'b00});

        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clock);
        check("rst_awready", bus.awready, 1'b1);
        check("rst_arready", bus.arready, 1'b1);
        check("rst_wready", bus.wready, 1'b0);
        check("rst_bvalid", bus.bvalid, 1'b0);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_rlast", bus.rlast, 1'b0);
        check("rst_bresp", bus.bresp, 2'b00);
        check("rst_rresp", bus.rresp, 2'b00);
        check("rst_bid", bus.bid, 4'd0);
        check("rst_rid", bus.rid, 4'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            write1(vecs[i].addr, 4'(i + 2), vecs[i].wdata, vecs[i].wstrb, vecs[i].wlast,
                   vecs[i].exp_bresp, $sformatf("vec%0d_wr", i));
            read1(vecs[i].addr, 4'(i + 5), vecs[i].exp_rdata, vecs[i].exp_rresp,
                  $sformatf("vec%0d_rd", i));
        end
        // Out-of-range writes must not alias onto in-range words.
        read1(BASE, 4'd1, 64'hDEAD_BEEF_0BAD_F00D, 2'b00, "oor_no_alias_low");
        read1(BASE + SPAN - 8, 4'd1, 64'h5555_6666_7777_8888, 2'b00, "oor_no_alias_high");

        // ---------------- read and write to the same word, same cycle ----
        do_aw(BASE + 32'h040, 4'd5, 8'd0, 2'b01);
        bus.wvalid = 1'b1; bus.wdata = 64'h2222_2222_2222_2222; bus.wstrb = 8'hFF; bus.wlast = 1'b1;
        bus.arvalid = 1'b1; bus.araddr = BASE + 32'h040; bus.arid = 4'd6; bus.arlen = 0; bus.arburst = 2'b01;
        check("rw_wready", bus.wready, 1'b1);
        check("rw_arready", bus.arready, 1'b1);
        @(negedge clock);
        bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("rw_rvalid", bus.rvalid, 1'b1);
        do_r(4'd6, 64'h1111_1111_1111_1111, 2'b00, 1'b1, "rw_old_data");
        do_b(4'd5, 2'b00, "rw_b");
        read1(BASE + 32'h040, 4'd7, 64'h2222_2222_2222_2222, 2'b00, "rw_new_data");

        // ---------------- R stall: outputs hold while !rready ----------
        do_ar(BASE + 32'h010, 4'd7, 8'd0, 2'b01);
        repeat (4) begin
            @(negedge clock);
            check("rstall_rvalid", bus.rvalid, 1'b1);
            check("rstall_rdata", bus.rdata, 64'hAA22_3344_5566_77AA);
            check("rstall_rid", bus.rid, 4'd7);
            check("rstall_rlast", bus.rlast, 1'b1);
        end
        do_r(4'd7, 64'hAA22_3344_5566_77AA, 2'b00, 1'b1, "rstall_accept");

        // ---------------- B stall: bvalid holds while !bready ----------
        do_aw(BASE + 32'h060, 4'd11, 8'd0, 2'b01);
        do_w(64'h6060_6060_6060_6060, 8'hFF, 1'b1);
        repeat (3) begin
            @(negedge clock);
            check("bstall_bvalid", bus.bvalid, 1'b1);
            check("bstall_bid", bus.bid, 4'd11);
            check("bstall_bresp", bus.bresp, 2'b00);
            check("bstall_awready", bus.awready, 1'b0);
        end
        do_b(4'd11, 2'b00, "bstall_accept");

        // ---------------- reset while a read is pending ----------------
        do_ar(BASE + 32'h060, 4'd12, 8'd0, 2'b01);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rdrst_rvalid", bus.rvalid, 1'b0);
        check("rdrst_arready", bus.arready, 1'b1);
        check("rdrst_rdata", bus.rdata, 64'd0);
        check("rdrst_rid", bus.rid, 4'd0);
        @(negedge clock);
        check("rdrst_no_r_beat", bus.rvalid, 1'b0);

`ifdef AXI_SRAM_SLAVE_BURST_EN
        begin
            logic [63:0] q[$];
            // INCR 4 beats, then read back with rready toggling
            do_aw(BASE + 32'h100, 4'd3, 8'd3, 2'b01);
            for (int k = 1; k <= 4; k++) begin
                do_w(64'(k), 8'hFF, k == 4);
                if (k < 4) check("incr_no_early_b", bus.bvalid, 1'b0);
            end
            do_b(4'd3, 2'b00, "incr4_b");
            q = '{64'd1, 64'd2, 64'd3, 64'd4};
            read_toggle(BASE + 32'h100, 8'd3, q, "incr4_rd");

            // wlast on the wrong beat
            do_aw(BASE + 32'h140, 4'd4, 8'd1, 2'b01);
            do_w(64'hA, 8'hFF, 1'b1);
            check("wlast_err_still_data", bus.wready, 1'b1);
            check("wlast_err_no_early_b", bus.bvalid, 1'b0);
            do_w(64'hB, 8'hFF, 1'b1);
            do_b(4'd4, 2'b10, "wlast_err_b");

            // FIXED burst stays on one word
            write1(BASE + 32'h188, 4'd1, 64'h99, 8'hFF, 1'b1, 2'b00, "fix_pre");
            do_aw(BASE + 32'h180, 4'd2, 8'd1, 2'b00);
            do_w(64'h77, 8'hFF, 1'b0);
            do_w(64'h88, 8'hFF, 1'b1);
            do_b(4'd2, 2'b00, "fix_b");
            do_ar(BASE + 32'h180, 4'd2, 8'd1, 2'b00);
            do_r(4'd2, 64'h88, 2'b00, 1'b0, "fix_rd0");
            do_r(4'd2, 64'h88, 2'b00, 1'b1, "fix_rd1");
            read1(BASE + 32'h188, 4'd2, 64'h99, 2'b00, "fix_neighbour");

            // WRAP behaves like INCR
            do_aw(BASE + 32'h1C0, 4'd6, 8'd1, 2'b10);
            do_w(64'hAAA, 8'hFF, 1'b0);
            do_w(64'hBBB, 8'hFF, 1'b1);
            do_b(4'd6, 2'b00, "wrap_b");
            do_ar(BASE + 32'h1C0, 4'd6, 8'd1, 2'b10);
            do_r(4'd6, 64'hAAA, 2'b00, 1'b0, "wrap_rd0");
            do_r(4'd6, 64'hBBB, 2'b00, 1'b1, "wrap_rd1");

            // Burst running off the top of the window
            do_aw(BASE + SPAN - 8, 4'd8, 8'd1, 2'b01);
            do_w(64'hE0E0, 8'hFF, 1'b0);
            do_w(64'hE1E1, 8'hFF, 1'b1);
            do_b(4'd8, 2'b11, "edge_b");
            do_ar(BASE + SPAN - 8, 4'd8, 8'd1, 2'b01);
            do_r(4'd8, 64'hE0E0, 2'b00, 1'b0, "edge_rd0");
            do_r(4'd8, 64'h0, 2'b11, 1'b1, "edge_rd1");

            // Reset during beat 2 of 4
            write1(BASE + 32'h210, 4'd1, 64'h0, 8'hFF, 1'b1, 2'b00, "mid_pre");
            do_aw(BASE + 32'h200, 4'd9, 8'd3, 2'b01);
            do_w(64'h10, 8'hFF, 1'b0);
            do_w(64'h20, 8'hFF, 1'b0);
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            check("mid_rst_awready", bus.awready, 1'b1);
            check("mid_rst_bvalid", bus.bvalid, 1'b0);
            check("mid_rst_wready", bus.wready, 1'b0);
            @(negedge clock);
            check("mid_rst_no_b", bus.bvalid, 1'b0);
            read1(BASE + 32'h200, 4'd1, 64'h10, 2'b00, "mid_beat0_kept");
            read1(BASE + 32'h208, 4'd1, 64'h20, 2'b00, "mid_beat1_kept");
            read1(BASE + 32'h210, 4'd1, 64'h0, 2'b00, "mid_beat2_absent");
        end
`else
        // Reset in W_DATA, before the data beat
        do_aw(BASE + 32'h050, 4'd9, 8'd0, 2'b01);
        check("wrst_in_wdata", bus.wready, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("wrst_awready", bus.awready, 1'b1);
        check("wrst_bvalid", bus.bvalid, 1'b0);
        check("wrst_wready", bus.wready, 1'b0);
        @(negedge clock);
        check("wrst_no_b", bus.bvalid, 1'b0);
        read1(BASE + 32'h050, 4'd1, 64'h5050_5050_5050_5050, 2'b00, "wrst_mem_kept");
`endif

        // ---------------- randomized phase ----------------
        run_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
